// File: rtl/crc_lut_engine.sv
// crc_lut_engine: table-driven MSB-first CRC-32 engine with a runtime-loadable polynomial.
//
// After reset, or whenever a new polynomial is loaded, a 256-entry lookup table is rebuilt.
// The rebuild writes one entry per cycle and takes 256 cycles. Once the table is ready, the
// engine accepts beats of LANES bytes. It chains every lane of a beat through the table within
// a single cycle. The final CRC is held until the consumer takes it.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   cfg_poly, cfg_load polynomial and single-cycle load request (triggers a table rebuild)
//   busy               table rebuild in progress
//   in_valid/in_ready  input beat handshake; in_data lane 0 = bits [7:0] is processed first
//   in_sop, in_eop     message framing; in_nbytes = valid bytes in the eop beat
//   out_valid/ready    final CRC handshake; out_crc = CRC register ^ XOROUT
//   tbl_addr/rdata     combinational debug read of the lookup table
module crc_lut_engine #(
  parameter int unsigned LANES    = 1,
  parameter logic [31:0] POLY_RST = 32'h04C11DB7,
  parameter logic [31:0] INIT     = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT   = 32'h00000000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [31:0]        cfg_poly,
  input  logic               cfg_load,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [2:0]         in_nbytes,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_crc,
  input  logic [7:0]         tbl_addr,
  output logic [31:0]        tbl_rdata
);

  localparam logic [1:0] ST_BUILD = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] poly_q, poly_d;
  logic [31:0] crc_q, crc_d;

  // Not reset: every entry is rewritten by the rebuild that follows reset.
  logic [31:0] tbl [256];

  logic [31:0] entry;
  logic [31:0] beat_crc;
  int unsigned nb_eff;
  logic        accept;

  assign busy      = (state_q == ST_BUILD);
  assign in_ready  = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_HOLD);
  assign out_crc   = crc_q ^ XOROUT;
  assign tbl_rdata = tbl[tbl_addr];
  assign accept    = in_valid & in_ready;

  // Table entry for idx_q: the byte is shifted MSB-first through the polynomial, starting
  // from a zero seed.
  always_comb begin
    entry = {idx_q, 24'h000000};
    for (int b = 0; b < 8; b++) begin
      entry = entry[31] ? ((entry << 1) ^ poly_q) : (entry << 1);
    end
  end

  // Lane chain for one beat. An eop beat uses only its first nb_eff lanes. An nbytes value
  // outside 1..LANES is treated as a full beat.
  always_comb begin
    nb_eff = LANES;
    if (in_eop && (in_nbytes != 3'd0) && (32'(in_nbytes) <= LANES)) begin
      nb_eff = 32'(in_nbytes);
    end
    beat_crc = in_sop ? INIT : crc_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (l < nb_eff) begin
        beat_crc = tbl[beat_crc[31:24] ^ in_data[8*l +: 8]] ^ {beat_crc[23:0], 8'h00};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    poly_d  = poly_q;
    crc_d   = crc_q;
    if (cfg_load) begin
      // A load overrides everything, including a beat accepted in the same cycle.
      state_d = ST_BUILD;
      idx_d   = 8'h00;
      poly_d  = cfg_poly;
      crc_d   = INIT;
    end else begin
      case (state_q)
        ST_BUILD: begin
          idx_d = idx_q + 8'd1;
          if (idx_q == 8'hFF) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (accept) begin
            crc_d = beat_crc;
            if (in_eop) state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_BUILD;
          idx_d   = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_BUILD;
      idx_q   <= 8'h00;
      poly_q  <= POLY_RST;
      crc_q   <= INIT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      poly_q  <= poly_d;
      crc_q   <= crc_d;
    end
  end

  // No write in a load cycle: the entry computed that cycle uses the outgoing polynomial.
  always_ff @(posedge clk) begin
    if ((state_q == ST_BUILD) && !cfg_load) begin
      tbl[idx_q] <= entry;
    end
  end

endmodule
